// File: rtl/imem_pkg.sv
// imem_pkg -- shared definitions for the loadable instruction memory.
//   NOP         : instruction returned whenever the fetch is not valid
//   imem_state_e: load state machine encoding (IDLE, LOAD, DONE)
//   idx_width() : word-index width for a given memory depth
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } imem_state_e;

  // ceil(log2(depth)), minimum 1
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(depth)) w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer -- assembles serial load bytes into 32-bit words.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : drop any partial word and restart at lane 0
//   accept        : data is taken this cycle
//   data, last    : incoming byte and end-of-image qualifier
//   word          : assembled word including the byte taken this cycle,
//                   unfilled lanes zero
//   word_done     : word is complete (4th byte or last) this cycle
module imem_byte_packer #(
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [31:0] partial;
  logic [4:0]  shamt;

  // Big endian puts lane 0 at [31:24]; little endian at [7:0].
  assign shamt     = (BIG_ENDIAN != 0) ? {~lane, 3'b000} : {lane, 3'b000};
  assign word      = partial | ({24'b0, data} << shamt);
  assign word_done = accept & (last | (lane == 2'd3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane    <= '0;
      partial <= '0;
    end else if (clear) begin
      lane    <= '0;
      partial <= '0;
    end else if (accept) begin
      if (word_done) begin
        lane    <= '0;
        partial <= '0;
      end else begin
        lane    <= lane + 2'd1;
        partial <= word;
      end
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable -- run-time loadable instruction memory for the MIPS core.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity + parity_err).
//   clk, rst             : clock, asynchronous active-low reset
//   load_start           : pulse, (re)start a load at word 0
//   load_valid/byte/last : byte-serial load stream, accepted when load_ready
//   load_ready           : load port accepts a byte (state LOAD)
//   load_busy            : load in progress
//   load_done            : image complete, sticky until load_start/reset
//   load_words           : words written by the last/current load
//   pc                   : fetch byte address
//   instr                : combinational instruction at pc (NOP if invalid)
//   instr_valid          : instr comes from loaded memory
//   fetch_fault          : pc misaligned or beyond the loaded image
//   parity_err           : stored parity mismatch (IMEM_PARITY_EN only)
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [7:0]                 load_byte,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic                       load_busy,
  output logic                       load_done,
  output logic [idx_width(DEPTH):0]  load_words,
  input  logic [PC_W-1:0]            pc,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic                       fetch_fault
`ifdef IMEM_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned WC_W  = IDX_W + 1;

  imem_state_e        state;
  logic               accept;
  logic               wr_en;
  logic [31:0]        wr_word;
  logic [IDX_W-1:0]   wr_idx;
  logic               last_slot;

  logic [31:0]        mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic               par_mem [DEPTH];
  logic               rd_par;
`endif

  logic [IDX_W-1:0]   rd_idx;
  logic [31:0]        rd_word;
  logic               aligned;
  logic               in_range;

  // Status flags are pure decodes of the state register.
  assign load_ready = (state == LOAD);
  assign load_busy  = (state == LOAD);
  assign load_done  = (state == DONE);

  // A byte offered together with load_start is dropped.
  assign accept    = load_valid & load_ready & ~load_start;
  assign wr_idx    = load_words[IDX_W-1:0];
  assign last_slot = (load_words == WC_W'(DEPTH - 1));

  imem_byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .accept    (accept),
    .data      (load_byte),
    .last      (load_last),
    .word      (wr_word),
    .word_done (wr_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      load_words <= '0;
    end else if (load_start) begin
      state      <= LOAD;
      load_words <= '0;
    end else if ((state == LOAD) && wr_en) begin
      load_words <= load_words + 1'b1;
      if (load_last || last_slot) state <= DONE;
    end
  end

  // Array is intentionally not reset; load_words == 0 hides stale content.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
`ifdef IMEM_PARITY_EN
      par_mem[wr_idx] <= ^wr_word;
`endif
    end
  end

  assign rd_idx   = pc[2 +: IDX_W];
  assign rd_word  = mem[rd_idx];
  assign aligned  = (pc[1:0] == 2'b00);
  assign in_range = ((pc >> 2) < PC_W'(load_words));
`ifdef IMEM_PARITY_EN
  assign rd_par   = par_mem[rd_idx];
`endif

  always_comb begin
    instr       = NOP;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
`ifdef IMEM_PARITY_EN
    parity_err  = 1'b0;
`endif
    if ((state == LOAD) || (load_words == '0)) begin
      instr = NOP;
    end else if (aligned && in_range) begin
`ifdef IMEM_PARITY_EN
      if ((^rd_word) != rd_par) begin
        parity_err = 1'b1;
      end else begin
        instr       = rd_word;
        instr_valid = 1'b1;
      end
`else
      instr       = rd_word;
      instr_valid = 1'b1;
`endif
    end else begin
      fetch_fault = 1'b1;
    end
  end

endmodule
